// File: rtl/instr_loader.sv
// Byte-stream program loader for the 9-bit instruction memory: parses a
// 16-bit word count header, rebuilds words and holds the core in reset.
module instr_loader #(
  parameter int D = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         wr_en,
  output logic [D-1:0] wr_addr,
  output logic [8:0]   wr_data,
  output logic         core_hold,
  output logic         load_done,
  output logic         hdr_err
);

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    INS_LO,
    INS_HI,
    DONE
  } state_e;

  state_e       state_q;
  logic [7:0]   cnt_lo_q;
  logic [7:0]   lo_byte_q;
  logic [D-1:0] n_q;
  logic [D-1:0] ptr_q;
  logic         in_ready_q;
  logic         wr_en_q;
  logic [D-1:0] wr_addr_q;
  logic [8:0]   wr_data_q;
  logic         core_hold_q;
  logic         load_done_q;
  logic         hdr_err_q;

  logic         accept;
  logic [15:0]  count_d;
  logic [D-1:0] n_d;
  logic [D-1:0] ptr_d;

  // Any count bit at or above position D cannot be addressed by the pointer.
  function automatic logic count_overflow(input logic [15:0] count);
    logic ovf;
    ovf = 1'b0;
    for (int i = D; i < 16; i++) begin
      ovf = ovf | count[i];
    end
    return ovf;
  endfunction

  assign accept  = in_valid & in_ready_q;
  assign count_d = {in_data, cnt_lo_q};
  assign n_d     = count_d[D-1:0];
  assign ptr_d   = ptr_q + D'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HDR_LO;
      ptr_q       <= '0;
      in_ready_q  <= 1'b1;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      core_hold_q <= 1'b1;
      load_done_q <= 1'b0;
      hdr_err_q   <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      // Completion is flagged one cycle after DONE is entered so the final
      // write lands before the core is released.
      if (state_q == DONE) begin
        load_done_q <= 1'b1;
        core_hold_q <= 1'b0;
      end
      case (state_q)
        HDR_LO: begin
          if (accept) begin
            cnt_lo_q <= in_data;
            state_q  <= HDR_HI;
          end
        end
        HDR_HI: begin
          if (accept) begin
            n_q       <= n_d;
            hdr_err_q <= count_overflow(count_d);
            if (n_d == '0) begin
              state_q    <= DONE;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= INS_LO;
            end
          end
        end
        INS_LO: begin
          if (accept) begin
            lo_byte_q <= in_data;
            state_q   <= INS_HI;
          end
        end
        INS_HI: begin
          if (accept) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= ptr_q;
            wr_data_q <= {in_data[0], lo_byte_q};
            ptr_q     <= ptr_d;
            if (ptr_d == n_q) begin
              state_q    <= DONE;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= INS_LO;
            end
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q    <= HDR_LO;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign core_hold = core_hold_q;
  assign load_done = load_done_q;
  assign hdr_err   = hdr_err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: per-cycle vector table plus a stalled
// stream sequence checked against a small byte-index model.
module tb_instr_loader;

  localparam int D = 12;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         wr_en;
  logic [D-1:0] wr_addr;
  logic [8:0]   wr_data;
  logic         core_hold;
  logic         load_done;
  logic         hdr_err;

  int checks   = 0;
  int failures = 0;

  instr_loader #(.D(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .core_hold (core_hold),
    .load_done (load_done),
    .hdr_err   (hdr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector: {wr_en, wr_addr, wr_data, in_ready, load_done, core_hold, hdr_err}
  typedef struct {
    logic        rst;
    logic        v;
    logic [7:0]  d;
    logic [25:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [25:0] ex(input logic we, input logic [11:0] a,
                                     input logic [8:0] wd, input logic rdy,
                                     input logic done, input logic hold,
                                     input logic err);
    return {we, a, wd, rdy, done, hold, err};
  endfunction

  function automatic logic [25:0] outs();
    return {wr_en, wr_addr, wr_data, in_ready, load_done, core_hold, hdr_err};
  endfunction

  task automatic add(input logic rst, input logic v, input logic [7:0] d,
                     input logic [25:0] e);
    vec_t t;
    t.rst = rst; t.v = v; t.d = d; t.exp = e;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic [7:0] d);
    @(negedge clk);
    reset    = rst;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  logic [25:0] RST;
  logic [25:0] IDLE;
  logic [7:0]  stream [8];
  logic [8:0]  exp_word [3];

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    RST  = ex(0, 12'h000, 9'h000, 1, 0, 1, 0);
    IDLE = RST;

    // Reset values and first cycle after reset
    add(1, 0, 8'h00, RST);
    add(1, 0, 8'h00, RST);
    add(0, 0, 8'h00, IDLE);
    // Basic load: 03 00 | 5A 01 | FF 00 | 12 03
    add(0, 1, 8'h03, IDLE);
    add(0, 1, 8'h00, IDLE);
    add(0, 1, 8'h5A, IDLE);
    add(0, 1, 8'h01, ex(1, 12'h000, 9'h15A, 1, 0, 1, 0));
    add(0, 1, 8'hFF, ex(0, 12'h000, 9'h15A, 1, 0, 1, 0));
    add(0, 1, 8'h00, ex(1, 12'h001, 9'h0FF, 1, 0, 1, 0));
    add(0, 1, 8'h12, ex(0, 12'h001, 9'h0FF, 1, 0, 1, 0));
    add(0, 1, 8'h03, ex(1, 12'h002, 9'h112, 0, 0, 1, 0));
    add(0, 1, 8'hAA, ex(0, 12'h002, 9'h112, 0, 1, 0, 0));
    add(0, 0, 8'h00, ex(0, 12'h002, 9'h112, 0, 1, 0, 0));
    // Empty program
    add(1, 0, 8'h00, RST);
    add(0, 1, 8'h00, IDLE);
    add(0, 1, 8'h00, ex(0, 12'h000, 9'h000, 0, 0, 1, 0));
    add(0, 0, 8'h00, ex(0, 12'h000, 9'h000, 0, 1, 0, 0));
    add(0, 1, 8'h55, ex(0, 12'h000, 9'h000, 0, 1, 0, 0));
    // Header overflow: 01 F0 then one record
    add(1, 0, 8'h00, RST);
    add(0, 1, 8'h01, IDLE);
    add(0, 1, 8'hF0, ex(0, 12'h000, 9'h000, 1, 0, 1, 1));
    add(0, 1, 8'h34, ex(0, 12'h000, 9'h000, 1, 0, 1, 1));
    add(0, 1, 8'h01, ex(1, 12'h000, 9'h134, 0, 0, 1, 1));
    add(0, 0, 8'h00, ex(0, 12'h000, 9'h134, 0, 1, 0, 1));
    // Reset after the low byte of word 2 of a 4-word load, then a 1-word load
    add(1, 0, 8'h00, RST);
    add(0, 1, 8'h04, IDLE);
    add(0, 1, 8'h00, IDLE);
    add(0, 1, 8'h11, IDLE);
    add(0, 1, 8'h00, ex(1, 12'h000, 9'h011, 1, 0, 1, 0));
    add(0, 1, 8'h22, ex(0, 12'h000, 9'h011, 1, 0, 1, 0));
    add(0, 1, 8'h01, ex(1, 12'h001, 9'h122, 1, 0, 1, 0));
    add(0, 1, 8'h33, ex(0, 12'h001, 9'h122, 1, 0, 1, 0));
    add(1, 0, 8'h00, RST);
    add(0, 1, 8'h01, IDLE);
    add(0, 1, 8'h00, IDLE);
    add(0, 1, 8'h44, IDLE);
    add(0, 1, 8'h01, ex(1, 12'h000, 9'h144, 0, 0, 1, 0));
    add(0, 0, 8'h00, ex(0, 12'h000, 9'h144, 0, 1, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].v, vecs[i].d);
      check($sformatf("vec[%0d]", i), {6'd0, outs()}, {6'd0, vecs[i].exp});
    end

    // Stalled basic load: model tracks accepted byte index
    stream[0] = 8'h03; stream[1] = 8'h00; stream[2] = 8'h5A; stream[3] = 8'h01;
    stream[4] = 8'hFF; stream[5] = 8'h00; stream[6] = 8'h12; stream[7] = 8'h03;
    exp_word[0] = 9'h15A; exp_word[1] = 9'h0FF; exp_word[2] = 9'h112;
    begin
      int writes;
      int nst;
      writes = 0;
      step(1, 0, 8'h00);
      step(1, 0, 8'h00);
      for (int b = 0; b < 8; b++) begin
        nst = (b == 3 || b == 5) ? 2 : int'($urandom_range(0, 2));
        for (int s = 0; s < nst; s++) begin
          step(0, 0, 8'hEE);
          check($sformatf("stall_we[b%0d s%0d]", b, s), {31'd0, wr_en}, 32'd0);
        end
        step(0, 1, stream[b]);
        if (b >= 3 && (b % 2) == 1) begin
          check($sformatf("stall_we[b%0d]", b), {31'd0, wr_en}, 32'd1);
          check($sformatf("stall_addr[%0d]", writes), {20'd0, wr_addr},
                writes);
          check($sformatf("stall_data[%0d]", writes), {23'd0, wr_data},
                {23'd0, exp_word[writes]});
          writes++;
        end else begin
          check($sformatf("stall_we[b%0d]", b), {31'd0, wr_en}, 32'd0);
        end
      end
      step(0, 0, 8'h00);
      check("stall_done", {29'd0, load_done, core_hold, in_ready}, 32'b100);
      check("stall_writes", writes, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Writes a program into the 9-bit instruction memory that the core's `instr_ROM` reads, so software can be replaced without resynthesis. The block receives a byte stream over a valid/ready handshake, rebuilds 9-bit machine-code words and writes them to sequential addresses. It holds the core in reset while loading and releases it once the last word is committed. It sits between the host byte source and the write port of the instruction memory, beside `top_level`.

## Interface
- D, 12, instruction address width; must match the core's PC width; 1 ≤ D ≤ 16.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  `in_data` holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- wr_en  output  1  instruction memory write strobe, one cycle per word.
- wr_addr  output  D  write address.
- wr_data  output  9  machine code word.
- core_hold  output  1  drive into the core's `reset` (OR with system reset); high while loading.
- load_done  output  1  program fully written; sticky until reset.
- hdr_err  output  1  header count had bits set above bit D-1; sticky until reset.

## Operation
- **Byte transfer.** A byte is accepted on a rising edge when `in_valid & in_ready`. `in_data` is ignored at any other time.
- **Stream format:**
  - Header byte 0: count[7:0].
  - Header byte 1: count[15:8].
  - Then N instruction records, where N = count[D-1:0]. Each record is two bytes:
    - Low byte: `mach_code[7:0]`.
    - High byte: bit0 is `mach_code[8]`; bits 7:1 are ignored.
- **Header error.** If count has any bit set at position ≥ D, `hdr_err` is set. Loading proceeds with the truncated N.
- **States:**
  - HDR_LO: accept byte → latch count low → HDR_HI.
  - HDR_HI: accept byte → latch count high, compute N. N=0 → DONE. Otherwise → INS_LO.
  - INS_LO: accept byte → latch data low → INS_HI.
  - INS_HI: accept byte → register the write (`wr_en`=1 next cycle, `wr_addr`=ptr, `wr_data`={bit0, low}) and increment ptr. If this was word N → DONE, else → INS_LO.
  - DONE: terminal until reset.
- `in_ready` = 1 in HDR_LO, HDR_HI, INS_LO and INS_HI; 0 in DONE. Bytes presented in DONE are not consumed.
- The word pointer is D bits, starts at 0 and increments by 1 per word. It never wraps, because N ≤ 2^D−1.
- `core_hold` is 1 from reset until `load_done` rises, then 0.
- `wr_addr`/`wr_data` hold their last written value when `wr_en`=0.
- **Reset mid-load.** All state returns to HDR_LO, the pointer to 0, and any partial record or header is discarded. Words already written stay in memory.

## Timing
- Reset values: `in_ready`=1, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `core_hold`=1, `load_done`=0, `hdr_err`=0, state HDR_LO.
- Throughput: one byte per cycle when `in_valid` is held high, giving one write every 2 cycles.
- Write latency: `wr_en` is high in the cycle immediately after the edge that accepts a record's high byte. Address and data are valid in that same cycle.
- Final word: the write cycle coincides with the first DONE cycle. `load_done`=1 and `core_hold`=0 from the next cycle onward. The memory therefore commits the last word before the core leaves reset.
- N=0: DONE is entered on the edge after HDR_HI. `load_done` rises one cycle later, and no `wr_en` pulse occurs.
- Stalls (`in_valid`=0) may occur between any bytes, including inside a record. State is held and `wr_en` stays 0.
- `hdr_err` updates on the edge that accepts header byte 1.

## Test plan
- **Reset values.** Assert reset 2 cycles → all outputs at their reset values. `core_hold`=1 and `in_ready`=1 in the first cycle after reset.
- **Basic load.** Stream 03 00 | 5A 01 | FF 00 | 12 03 back-to-back → exactly 3 `wr_en` pulses, on cycles 4, 6 and 8 after the first accept:
  - addr 0 = 0x15A
  - addr 1 = 0x0FF
  - addr 2 = 0x112 (upper bits of 0x03 ignored)

  `load_done`=1 and `core_hold`=0 one cycle after the third pulse, and `in_ready`=0 thereafter.
- **Empty program.** Stream 00 00 → no `wr_en` pulse; `load_done` rises 2 cycles after the second accept.
- **Stall tolerance.** Same stream as the basic load with `in_valid` randomly deasserted, including between the low and high byte of a record → identical writes and addresses; `wr_en` is never asserted during a stall.
- **Header overflow.** With D=12, stream 01 F0 then one record → `hdr_err`=1, N=1, a single write to addr 0, then DONE.
- **Reset mid-operation.** Assert reset after the low byte of word 2 of a 4-word load, then restream a 1-word program → the write lands at addr 0, `hdr_err`=0, and `load_done` follows the second load only.
